// File: rtl/lcd_cmd_seq.sv
// Opcode FIFO and issue sequencer feeding the LCD image controller.
// Strobes one opcode at a time and tracks the controller's busy/done handshake.
module lcd_cmd_seq #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     busy,
    input  logic                     done,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               issued_cnt,
    output logic                     bad_cmd,
    output logic                     ack_err,
    output logic                     seq_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_IDLE,
        WAIT_DONE,
        FINISH,
        ERROR
    } state_t;

    state_t        state, state_n;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [TW-1:0] tmr, tmr_n;
    logic [3:0]    cmd_n;
    logic          cmd_valid_n;
    logic [7:0]    issued_n;
    logic          ack_err_n, seq_done_n;
    logic          full, empty, push, push_ok, pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign host_ready = !full && (state != WAIT_DONE)
                     && (state != FINISH) && (state != ERROR);
    assign push    = host_valid && host_ready;
    assign push_ok = push && (host_cmd < 4'hC);
    assign fifo_level = level;

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        tmr_n       = tmr;
        cmd_n       = cmd;
        cmd_valid_n = cmd_valid;
        issued_n    = issued_cnt;
        ack_err_n   = ack_err;
        seq_done_n  = seq_done;
        case (state)
            IDLE: begin
                if (!empty && !busy) begin
                    pop         = 1'b1;
                    cmd_n       = mem[rd_ptr];
                    cmd_valid_n = 1'b1;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                // cmd still holds the opcode being strobed this cycle
                cmd_n       = 4'h0;
                cmd_valid_n = 1'b0;
                tmr_n       = '0;
                if (issued_cnt != 8'hFF)
                    issued_n = issued_cnt + 8'd1;
                state_n = (cmd == 4'h0) ? WAIT_DONE : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_n = WAIT_IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                    if (tmr_n == TW'(ACK_TIMEOUT)) begin
                        state_n   = ERROR;
                        ack_err_n = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!busy)
                    state_n = IDLE;
            end
            WAIT_DONE: begin
                if (done) begin
                    seq_done_n = 1'b1;
                    state_n    = FINISH;
                end
            end
            FINISH:  state_n = FINISH;
            ERROR:   state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tmr        <= '0;
            cmd        <= 4'h0;
            cmd_valid  <= 1'b0;
            issued_cnt <= 8'd0;
            ack_err    <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            cmd        <= cmd_n;
            cmd_valid  <= cmd_valid_n;
            issued_cnt <= issued_n;
            ack_err    <= ack_err_n;
            seq_done   <= seq_done_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            bad_cmd <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (!push_ok && pop)
                level <= level - 1'b1;
            if (push && !push_ok)
                bad_cmd <= 1'b1;
        end
    end

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= host_cmd;
    end

endmodule

// File: doc/lcd_cmd_seq.md
# lcd_cmd_seq

Command sequencer that sits directly upstream of the LCD image controller. It accepts image-operation opcodes from a host through a valid/ready port and buffers them in a small FIFO. It issues them one at a time on the controller's `cmd`/`cmd_valid` inputs, obeying the controller's `busy` handshake. After issuing the write-out opcode (0), it waits for the controller's `done` pulse and then reports sequence completion.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ACK_TIMEOUT`, 4: cycles allowed in WAIT_ACK for `busy` to rise before error.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `host_cmd`  in  4  opcode from host.
- `host_valid`  in  1  host offers `host_cmd`.
- `host_ready`  out  1  block accepts; push = `host_valid & host_ready`.
- `busy`  in  1  controller busy.
- `done`  in  1  controller finished write-out.
- `cmd`  out  4  opcode to controller (registered).
- `cmd_valid`  out  1  opcode strobe to controller (registered).
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `issued_cnt`  out  8  commands issued since reset, saturating at 255.
- `bad_cmd`  out  1  sticky: an opcode 4'hC–4'hF was offered.
- `ack_err`  out  1  sticky: controller failed to acknowledge.
- `seq_done`  out  1  sticky: write-out completed.

## Operation
- Reset values: `cmd`=0, `cmd_valid`=0, `fifo_level`=0, `issued_cnt`=0, `bad_cmd`=0, `ack_err`=0, `seq_done`=0, state IDLE, FIFO empty.
- `host_ready` = !full & state ∉ {WAIT_DONE, FINISH, ERROR}. It is combinational from registered state and does not depend on a same-cycle pop.
- Push with opcode 4'h0–4'hB: the opcode is enqueued. Push with 4'hC–4'hF: handshake completes, nothing is enqueued, and `bad_cmd` is set.
- A push and a pop in the same cycle leave `fifo_level` unchanged. Read/write pointers wrap modulo DEPTH.
- `cmd` is driven to 0 whenever `cmd_valid`=0. The controller updates its window position from `cmd` without checking `cmd_valid`, so this rule is mandatory.
- States:
  - IDLE: if FIFO non-empty and `busy`=0, pop the head, load `cmd`, set `cmd_valid`=1, and go to ISSUE. Otherwise stay.
  - ISSUE: clear `cmd_valid`/`cmd` and increment `issued_cnt`. If the issued opcode is 0, go to WAIT_DONE; else go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK: if `busy`=1, go to WAIT_IDLE. Else increment the counter; when it reaches ACK_TIMEOUT, go to ERROR.
  - WAIT_IDLE: when `busy`=0, go to IDLE.
  - WAIT_DONE: when `done`=1, set `seq_done` and go to FINISH. No timeout.
  - FINISH, ERROR: terminal until reset. Opcodes remaining in the FIFO are never issued. ERROR sets `ack_err`.
- Reset asserted mid-operation: every register returns to its reset value immediately, and FIFO contents are discarded.

## Timing
- Push at edge P into an empty FIFO: `fifo_level`=1 after P. With `busy`=0, `cmd_valid` is high after P+1. First-word latency is 1 cycle.
- `cmd_valid` is high for exactly one cycle per command.
- Nominal controller: `busy` rises the cycle after the strobe and is high for 1 cycle. Back-to-back opcodes are then issued every 4 cycles (IDLE→ISSUE→WAIT_ACK→WAIT_IDLE→IDLE).
- While `busy`=1, including during the controller's image load after reset, no strobe is issued.

## Test plan
- Image load: `busy`=1 for 64 cycles, host pushes opcodes 1,4 -> no `cmd_valid` while busy. After `busy` falls: `cmd`=1 strobe, then `cmd`=4 strobe 4 cycles later. `issued_cnt`=2.
- FIFO fill: push 9 opcodes of 7 with `busy` held 1 -> `host_ready`=0 after the 8th push, `fifo_level`=8, and the 9th push stalls until the first pop.
- Write-out: push 5,0,3 -> 5 is issued, then 0. `host_ready` drops after the ISSUE of 0. `done` pulse -> `seq_done`=1. Opcode 3 is never issued and `fifo_level` stays 1.
- Timeout: issue opcode 8 with `busy` stuck 0 -> after 4 WAIT_ACK cycles, `ack_err`=1, `host_ready`=0, and no further strobes.
- Bad opcode: push 4'hE, then 2 -> `bad_cmd`=1, only `cmd`=2 is issued, `issued_cnt`=1, and `cmd`=0 in every cycle with `cmd_valid`=0.
- Reset mid-run: assert `reset`=0 during WAIT_IDLE with 3 entries queued -> all outputs return to reset values asynchronously, and `fifo_level`=0 after release.
